axi4_lite_addr_demux: RTL

AXI4_LITE_ADDR_DEMUX -- requirements
Module: axi4_lite_addr_demux

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_addr_decode.sv | 31 +++
 rtl/axi4_lite_addr_demux.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, demux FSM state encodings and the default
// slave-select field position.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_SEL_MSB = 31;
  localparam int DEF_SEL_LSB = 28;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP, WR_ERR} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_e;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decode: extracts addr[SEL_MSB:SEL_LSB] as the slave
// index and flags whether that index names an existing slave.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_MSB    = DEF_SEL_MSB,
  parameter int SEL_LSB    = DEF_SEL_LSB
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             mapped
);

  localparam int               FIELD_W    = SEL_MSB - SEL_LSB + 1;
  localparam int               MASK_I     = (1 << FIELD_W) - 1;
  localparam logic [IDX_W-1:0] FIELD_MASK = MASK_I[IDX_W-1:0];
  localparam logic [IDX_W:0]   NS         = NUM_SLAVES[IDX_W:0];

  logic [31:0] shifted;
  logic        unused_hi;

  always_comb begin
    shifted = addr >> SEL_LSB;
    idx     = shifted[IDX_W-1:0] & FIELD_MASK;
    mapped  = ({1'b0, idx} < NS);
  end

  assign unused_hi = ^shifted[31:IDX_W];

endmodule

// File: rtl/axi4_lite_addr_demux.sv
// AXI4-Lite 1:N address demultiplexer with independent write and read FSMs.
// Optional watchdog enabled by defining AXI_DEMUX_TIMEOUT_EN.
module axi4_lite_addr_demux
  import axi4_lite_pkg::*;
#(
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_MSB        = DEF_SEL_MSB,
  parameter int SEL_LSB        = DEF_SEL_LSB,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [31:0]              axi_awaddr,
  input  logic [2:0]               axi_awprot,
  input  logic                     axi_wvalid,
  output logic                     axi_wready,
  input  logic [31:0]              axi_wdata,
  input  logic [3:0]               axi_wstrb,
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  output logic [1:0]               axi_bresp,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  input  logic [31:0]              axi_araddr,
  input  logic [2:0]               axi_arprot,
  output logic                     axi_rvalid,
  input  logic                     axi_rready,
  output logic [31:0]              axi_rdata,
  output logic [1:0]               axi_rresp,
  output logic [NUM_SLAVES-1:0]    s_awvalid,
  input  logic [NUM_SLAVES-1:0]    s_awready,
  output logic [31:0]              s_awaddr,
  output logic [2:0]               s_awprot,
  output logic [NUM_SLAVES-1:0]    s_wvalid,
  input  logic [NUM_SLAVES-1:0]    s_wready,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_bvalid,
  output logic [NUM_SLAVES-1:0]    s_bready,
  input  logic [2*NUM_SLAVES-1:0]  s_bresp,
  output logic [NUM_SLAVES-1:0]    s_arvalid,
  input  logic [NUM_SLAVES-1:0]    s_arready,
  output logic [31:0]              s_araddr,
  output logic [2:0]               s_arprot,
  input  logic [NUM_SLAVES-1:0]    s_rvalid,
  output logic [NUM_SLAVES-1:0]    s_rready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [2*NUM_SLAVES-1:0]  s_rresp
);

  wr_state_e        wr_q, wr_d;
  rd_state_e        rd_q, rd_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0]      waddr_q, waddr_d, wdata_q, wdata_d, raddr_q, raddr_d;
  logic [2:0]       wprot_q, wprot_d, rprot_q, rprot_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [IDX_W-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [1:0]       werr_q, werr_d, rerr_q, rerr_d;

  logic [IDX_W-1:0] wdec_idx, rdec_idx;
  logic             wdec_mapped, rdec_mapped;
  logic             wr_hs, rd_hs, aw_fire, w_fire;
  logic             wr_timeout, rd_timeout;

  logic [NUM_SLAVES-1:0] wsel, rsel;
  logic                  ws_awready, ws_wready, ws_bvalid, rs_arready, rs_rvalid;
  logic [1:0]            ws_bresp, rs_rresp;
  logic [31:0]           rs_rdata;

  axi4_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .SEL_MSB(SEL_MSB), .SEL_LSB(SEL_LSB))
    u_wr_decode (.addr(axi_awaddr), .idx(wdec_idx), .mapped(wdec_mapped));

  axi4_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .SEL_MSB(SEL_MSB), .SEL_LSB(SEL_LSB))
    u_rd_decode (.addr(axi_araddr), .idx(rdec_idx), .mapped(rdec_mapped));

  // Select the registered slave's response signals; unselected slaves are ignored.
  always_comb begin
    wsel       = '0;
    rsel       = '0;
    ws_awready = 1'b0;
    ws_wready  = 1'b0;
    ws_bvalid  = 1'b0;
    ws_bresp   = RESP_OKAY;
    rs_arready = 1'b0;
    rs_rvalid  = 1'b0;
    rs_rresp   = RESP_OKAY;
    rs_rdata   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (widx_q == IDX_W'(k)) begin
        wsel[k]    = 1'b1;
        ws_awready = s_awready[k];
        ws_wready  = s_wready[k];
        ws_bvalid  = s_bvalid[k];
        ws_bresp   = s_bresp[2*k +: 2];
      end
      if (ridx_q == IDX_W'(k)) begin
        rsel[k]    = 1'b1;
        rs_arready = s_arready[k];
        rs_rvalid  = s_rvalid[k];
        rs_rresp   = s_rresp[2*k +: 2];
        rs_rdata   = s_rdata[32*k +: 32];
      end
    end
  end

`ifdef AXI_DEMUX_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  // Counters sit at the load value while idle and run down once a request leaves IDLE.
  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (wr_q == WR_IDLE)      wcnt_d = CNT_LOAD;
    else if (wcnt_q != '0)    wcnt_d = wcnt_q - CNT_W'(1);
    if (rd_q == RD_IDLE)      rcnt_d = CNT_LOAD;
    else if (rcnt_q != '0)    rcnt_d = rcnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= CNT_LOAD;
      rcnt_q <= CNT_LOAD;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign wr_timeout = (wcnt_q == '0);
  assign rd_timeout = (rcnt_q == '0);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_comb begin
    wr_d        = wr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    waddr_d     = waddr_q;
    wprot_d     = wprot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    widx_d      = widx_q;
    werr_d      = werr_q;
    wr_hs       = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = RESP_OKAY;
    s_awvalid   = '0;
    s_wvalid    = '0;
    s_bready    = '0;
    case (wr_q)
      WR_IDLE: begin
        wr_hs       = axi_awvalid & axi_wvalid & ~reset;
        axi_awready = wr_hs;
        axi_wready  = wr_hs;
        if (wr_hs) begin
          waddr_d   = axi_awaddr;
          wprot_d   = axi_awprot;
          wdata_d   = axi_wdata;
          wstrb_d   = axi_wstrb;
          widx_d    = wdec_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          werr_d    = RESP_DECERR;
          wr_d      = wdec_mapped ? WR_FWD : WR_ERR;
        end
      end
      WR_FWD: begin
        s_awvalid = wsel & {NUM_SLAVES{~aw_done_q}};
        s_wvalid  = wsel & {NUM_SLAVES{~w_done_q}};
        aw_fire   = ~aw_done_q & ws_awready;
        w_fire    = ~w_done_q & ws_wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
          wr_d = WR_RESP;
        end else if (wr_timeout) begin
          werr_d = RESP_SLVERR;
          wr_d   = WR_ERR;
        end
      end
      WR_RESP: begin
        axi_bvalid = ws_bvalid;
        axi_bresp  = ws_bresp;
        s_bready   = wsel & {NUM_SLAVES{axi_bready}};
        if (ws_bvalid & axi_bready) begin
          wr_d = WR_IDLE;
        end else if (wr_timeout) begin
          werr_d = RESP_SLVERR;
          wr_d   = WR_ERR;
        end
      end
      WR_ERR: begin
        axi_bvalid = 1'b1;
        axi_bresp  = werr_q;
        if (axi_bready) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_d        = rd_q;
    raddr_d     = raddr_q;
    rprot_d     = rprot_q;
    ridx_d      = ridx_q;
    rerr_d      = rerr_q;
    rd_hs       = 1'b0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = RESP_OKAY;
    s_arvalid   = '0;
    s_rready    = '0;
    case (rd_q)
      RD_IDLE: begin
        rd_hs       = axi_arvalid & ~reset;
        axi_arready = rd_hs;
        if (rd_hs) begin
          raddr_d = axi_araddr;
          rprot_d = axi_arprot;
          ridx_d  = rdec_idx;
          rerr_d  = RESP_DECERR;
          rd_d    = rdec_mapped ? RD_ADDR : RD_ERR;
        end
      end
      RD_ADDR: begin
        s_arvalid = rsel;
        if (rs_arready) begin
          rd_d = RD_DATA;
        end else if (rd_timeout) begin
          rerr_d = RESP_SLVERR;
          rd_d   = RD_ERR;
        end
      end
      RD_DATA: begin
        axi_rvalid = rs_rvalid;
        axi_rdata  = rs_rdata;
        axi_rresp  = rs_rresp;
        s_rready   = rsel & {NUM_SLAVES{axi_rready}};
        if (rs_rvalid & axi_rready) begin
          rd_d = RD_IDLE;
        end else if (rd_timeout) begin
          rerr_d = RESP_SLVERR;
          rd_d   = RD_ERR;
        end
      end
      RD_ERR: begin
        axi_rvalid = 1'b1;
        axi_rresp  = rerr_q;
        if (axi_rready) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= WR_IDLE;
      rd_q      <= RD_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      waddr_q   <= '0;
      wprot_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      widx_q    <= '0;
      werr_q    <= RESP_DECERR;
      raddr_q   <= '0;
      rprot_q   <= '0;
      ridx_q    <= '0;
      rerr_q    <= RESP_DECERR;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      waddr_q   <= waddr_d;
      wprot_q   <= wprot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      widx_q    <= widx_d;
      werr_q    <= werr_d;
      raddr_q   <= raddr_d;
      rprot_q   <= rprot_d;
      ridx_q    <= ridx_d;
      rerr_q    <= rerr_d;
    end
  end

  assign s_awaddr = waddr_q;
  assign s_awprot = wprot_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign s_araddr = raddr_q;
  assign s_arprot = rprot_q;

endmodule
